// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: float field layout, canonical encodings and
// the iterative divider's state encoding and special-operand flag indices.
package fpu_pkg;

    localparam int unsigned EXP_W      = 8;
    localparam int unsigned MAN_W      = 23;
    localparam int unsigned BIAS       = 127;
    localparam int unsigned FDIV_QBITS = 26;
    localparam int unsigned ED_W       = 10;
    localparam int unsigned CNT_W      = 5;

    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] INF_EXP = 8'hFF;

    // Bit positions within the latched special-operand flag vector
    localparam int unsigned FLG_W       = 5;
    localparam int unsigned FLG_X1_ZERO = 0;
    localparam int unsigned FLG_X2_ZERO = 1;
    localparam int unsigned FLG_X1_INF  = 2;
    localparam int unsigned FLG_X2_INF  = 3;
    localparam int unsigned FLG_NAN     = 4;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] expo;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fdiv_state_t;

endpackage

// File: rtl/fdiv_round_pack.sv
// Combinational normalise/round/pack stage of the divider: turns the raw
// quotient, exponent difference and special-operand flags into the result word.
module fdiv_round_pack
    import fpu_pkg::*;
(
    input  logic                  s,
    input  logic [ED_W-1:0]       ed,
    input  logic [FDIV_QBITS-1:0] q,
    input  logic [FLG_W-1:0]      flags,
    output logic [31:0]           y_c
);

    localparam logic signed [ED_W-1:0] ED_ZERO = '0;
    localparam logic signed [ED_W-1:0] ED_INF  = ED_W'(255);

    logic signed [ED_W-1:0] ed_s;
    logic signed [ED_W-1:0] ed_n;
    logic signed [ED_W-1:0] ed_f;
    logic [MAN_W:0]         mant;
    logic [MAN_W-1:0]       frac;
    logic                   rnd;
    logic                   carry;
    logic                   hi;

    assign ed_s = $signed(ed);

    // Quotient lies in [2^24, 2^26); pick the 24-bit window under the leading one
    always_comb begin
        hi    = q[FDIV_QBITS-1];
        mant  = hi ? q[FDIV_QBITS-1 -: MAN_W+1] : q[FDIV_QBITS-2 -: MAN_W+1];
        rnd   = hi ? q[1] : q[0];
        ed_n  = hi ? ed_s : ed_s - ED_W'(1);
        carry = (&mant) & rnd;
        frac  = mant[MAN_W-1:0] + MAN_W'(rnd);
        ed_f  = carry ? ed_n + ED_W'(1) : ed_n;
    end

    always_comb begin
        y_c = {s, 31'b0};
        if (flags[FLG_NAN])
            y_c = {s, INF_EXP, QNAN[MAN_W-1:0]};
        else if (flags[FLG_X1_INF])
            y_c = {s, INF_EXP, MAN_W'(0)};
        else if (flags[FLG_X2_INF])
            y_c = {s, 31'b0};
        else if (flags[FLG_X1_ZERO] && flags[FLG_X2_ZERO])
            y_c = {s, INF_EXP, QNAN[MAN_W-1:0]};
        else if (flags[FLG_X2_ZERO])
            y_c = {s, INF_EXP, MAN_W'(0)};
        else if (flags[FLG_X1_ZERO])
            y_c = {s, 31'b0};
        else if (ed_f <= ED_ZERO)
            y_c = {s, 31'b0};
        else if (ed_f >= ED_INF)
            y_c = {s, INF_EXP, MAN_W'(0)};
        else
            y_c = {s, ed_f[EXP_W-1:0], frac};
    end

endmodule

// File: rtl/fdiv_iter.sv
// Multi-cycle single-precision divider (radix-2 restoring, fixed latency).
// Define FDIV_SPECIAL_EN to decode exponent-255 operands as IEEE inf/NaN.
module fdiv_iter
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] y
);

    fdiv_state_t state, state_nxt;

    logic                  load_c, iter_c, wr_y_c, valid_nxt_c;
    logic [CNT_W-1:0]      cnt;
    logic [FDIV_QBITS-1:0] r;
    logic [FDIV_QBITS-1:0] r_sub;
    logic [MAN_W:0]        d;
    logic [FDIV_QBITS-1:0] q;
    logic                  qb;
    logic                  s;
    logic [ED_W-1:0]       ed;
    logic [ED_W-1:0]       ed_in_c;
    logic [FLG_W-1:0]      flags;
    logic [FLG_W-1:0]      flags_in_c;
    logic [31:0]           y_pack_c;
    fp32_t                 a, b;

    assign a = x1;
    assign b = x2;

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ready) state_nxt = CALC;
            CALC:    if (cnt == CNT_W'(FDIV_QBITS-1)) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_c      = 1'b0;
        iter_c      = 1'b0;
        wr_y_c      = 1'b0;
        valid_nxt_c = 1'b0;
        case (state)
            IDLE:    load_c = ready;
            CALC:    iter_c = 1'b1;
            NORM: begin
                wr_y_c      = 1'b1;
                valid_nxt_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand decode at acceptance; inf/NaN only exist in the special build
    always_comb begin
        ed_in_c                 = ED_W'(a.expo) - ED_W'(b.expo) + ED_W'(BIAS);
        flags_in_c              = '0;
        flags_in_c[FLG_X1_ZERO] = (a.expo == '0);
        flags_in_c[FLG_X2_ZERO] = (b.expo == '0);
`ifdef FDIV_SPECIAL_EN
        flags_in_c[FLG_X1_INF]  = (a.expo == INF_EXP) && (a.man == '0);
        flags_in_c[FLG_X2_INF]  = (b.expo == INF_EXP) && (b.man == '0);
        flags_in_c[FLG_NAN]     = ((a.expo == INF_EXP) && (a.man != '0))
                               || ((b.expo == INF_EXP) && (b.man != '0))
                               || (flags_in_c[FLG_X1_INF] && flags_in_c[FLG_X2_INF])
                               || (flags_in_c[FLG_X1_ZERO] && flags_in_c[FLG_X2_ZERO]);
`endif
    end

    assign qb    = (r >= {2'b00, d});
    assign r_sub = r - (qb ? {2'b00, d} : '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt   <= '0;
            r     <= '0;
            d     <= '0;
            q     <= '0;
            s     <= 1'b0;
            ed    <= '0;
            flags <= '0;
            y     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= valid_nxt_c;
            if (load_c) begin
                cnt   <= '0;
                r     <= {2'b00, 1'b1, a.man};
                d     <= {1'b1, b.man};
                q     <= '0;
                s     <= a.sign ^ b.sign;
                ed    <= ed_in_c;
                flags <= flags_in_c;
            end
            if (iter_c) begin
                cnt <= cnt + CNT_W'(1);
                r   <= r_sub << 1;
                q   <= {q[FDIV_QBITS-2:0], qb};
            end
            if (wr_y_c) y <= y_pack_c;
        end
    end

    fdiv_round_pack u_round_pack (
        .s     (s),
        .ed    (ed),
        .q     (q),
        .flags (flags),
        .y_c   (y_pack_c)
    );

endmodule

// File: tb/tb_fdiv_iter.sv
// Directed bench for fdiv_iter: expected quotients and valid cycles go to a
// scoreboard at issue time and are checked when valid pulses.
module tb_fdiv_iter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] x1, x2;
    logic        ready;
    logic        valid;
    logic [31:0] y;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] y;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fdiv_iter dut (
        .clk   (clk),
        .rstn  (rstn),
        .x1    (x1),
        .x2    (x2),
        .ready (ready),
        .valid (valid),
        .y     (y)
    );

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Every valid pulse must match the head of the scoreboard, in value and cycle
    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid cyc=%0d got=1 exp=0", cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check32(e.tag, y, e.y);
                check_int({e.tag, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input string tag);
        x1    = a;
        x2    = b;
        ready = 1'b1;
        sb.push_back('{y: e, cyc: cyc + 28, tag: tag});
        @(negedge clk);
        ready = 1'b0;
        x1    = $urandom;
        x2    = $urandom;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_int("drain_timeout", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input string tag);
        issue(a, b, e, tag);
        drain(40);
    endtask

    initial begin
        int t;
        rstn  = 1'b0;
        ready = 1'b0;
        x1    = '0;
        x2    = '0;
        repeat (3) @(negedge clk);
        check32("reset_y", y, 32'h0);
        check32("reset_valid", {31'b0, valid}, 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        // 6/2 with exact latency and result hold afterwards
        t = cyc;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, "six_by_two");
        drain(40);
        while (cyc < t + 40) @(negedge clk);
        check32("y_hold", y, 32'h40400000);

        run(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "one_third");
        run(32'hBF800000, 32'h3F800000, 32'hBF800000, "neg_one");
        run(32'hC0C00000, 32'hC0000000, 32'h40400000, "neg_by_neg");
        run(32'h3F800000, 32'hC0400000, 32'hBEAAAAAB, "neg_third");
        run(32'h3F800000, 32'h3F800000, 32'h3F800000, "one_by_one");
        run(32'h3F800000, 32'h00000000, 32'h7F800000, "div_by_zero");
        run(32'h00000000, 32'h00000000, 32'h7FC00000, "zero_by_zero");
        run(32'h80000000, 32'h40000000, 32'h80000000, "neg_zero");
        run(32'h00400000, 32'h3F800000, 32'h00000000, "denorm_num");
        run(32'h40000000, 32'h00000001, 32'h7F800000, "denorm_den");
        run(32'h00800000, 32'h7F000000, 32'h00000000, "underflow");
        run(32'h7F000000, 32'h00800000, 32'h7F800000, "overflow");
`ifdef FDIV_SPECIAL_EN
        run(32'h7F800000, 32'h3F800000, 32'h7F800000, "inf_by_one");
        run(32'h7FC00000, 32'h3F800000, 32'h7FC00000, "nan_by_one");
        run(32'h3F800000, 32'h7F800000, 32'h00000000, "one_by_inf");
        run(32'h7F800000, 32'h7F800000, 32'h7FC00000, "inf_by_inf");
        run(32'hFF800000, 32'h00000000, 32'hFF800000, "ninf_by_zero");
`else
        run(32'h7F800000, 32'h3F800000, 32'h7F800000, "exp255_overflow");
        run(32'h7FC00000, 32'h3F800000, 32'h7F800000, "exp255_plain");
`endif

        // ready held high: accepted at t and t+29 only
        t     = cyc;
        x1    = 32'h40C00000;
        x2    = 32'h40000000;
        ready = 1'b1;
        sb.push_back('{y: 32'h40400000, cyc: t + 28, tag: "held_first"});
        sb.push_back('{y: 32'h40400000, cyc: t + 57, tag: "held_second"});
        repeat (58) @(negedge clk);
        ready = 1'b0;
        drain(40);
        repeat (35) @(negedge clk);

        // reset mid-CALC discards the operation
        x1    = 32'h3F800000;
        x2    = 32'h40400000;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check32("midcalc_reset_y", y, 32'h0);
        check32("midcalc_reset_valid", {31'b0, valid}, 32'h0);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        check32("after_reset_y", y, 32'h0);

        run(32'h40C00000, 32'h40000000, 32'h40400000, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
